seq_divide: RTL and testbench

SEQ_DIVIDE -- requirements
Module: seq_divide

---
 rtl/seq_divide.sv | 178 +++++++++++++++++
 tb/tb_seq_divide.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/seq_divide.sv
// seq_divide -- sequential signed divider (restoring, one quotient bit per cycle).
//
// Purpose:
//   Divides a WIDTH-bit two's-complement dividend by a WIDTH-bit two's-complement
//   divisor. The quotient truncates toward zero and the remainder takes the sign
//   of the dividend. A zero divisor is reported on 'error' and yields zero results.
//   A nonzero division takes WIDTH+1 cycles from the start edge to the done pulse.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   request a division (sampled only while idle)
//   dividend   in   [WIDTH-1:0]   signed dividend
//   divisor    in   [WIDTH-1:0]   signed divisor
//   busy       out  high from the cycle after an accepted start through FIN
//   done       out  one-cycle pulse while the results become valid (FIN)
//   quotient   out  [2*WIDTH-1:0] signed quotient, sign-extended
//   remainder  out  [WIDTH-1:0]   signed remainder (only with SEQ_DIV_REMAINDER_EN)
//   error      out  divide-by-zero flag for the last result
//
// Configuration:
//   SEQ_DIV_REMAINDER_EN  define to include the remainder port and its sign fix-up.

module seq_divide #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   quotient,
`ifdef SEQ_DIV_REMAINDER_EN
  output logic [WIDTH-1:0]     remainder,
`endif
  output logic                 error
);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  localparam int CW = $clog2(WIDTH);

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH:0]       rem_q, rem_d;      // partial remainder
  logic [WIDTH:0]       quo_q, quo_d;      // dividend bits shift out, quotient bits shift in
  logic [WIDTH:0]       dvs_q, dvs_d;      // divisor magnitude
  logic                 neg_q, neg_d;      // operand signs differ
  logic [2*WIDTH-1:0]   quotient_q, quotient_d;
  logic                 error_q, error_d;
`ifdef SEQ_DIV_REMAINDER_EN
  logic                 dnd_neg_q, dnd_neg_d;
  logic [WIDTH-1:0]     remainder_q, remainder_d;
  logic [WIDTH-1:0]     r_mag;
`endif

  logic [WIDTH:0]       dnd_ext, dvs_ext, dnd_mag, dvs_mag;
  logic [WIDTH+1:0]     trial;
  logic                 qbit;
  logic [WIDTH:0]       rem_step, quo_step;
  logic [2*WIDTH-1:0]   q_ext;

  always_comb begin
    // One extra bit so that |-2^(WIDTH-1)| is exact.
    dnd_ext = {dividend[WIDTH-1], dividend};
    dvs_ext = {divisor[WIDTH-1], divisor};
    dnd_mag = dnd_ext[WIDTH] ? -dnd_ext : dnd_ext;
    dvs_mag = dvs_ext[WIDTH] ? -dvs_ext : dvs_ext;

    // Restoring step: shift in the next dividend bit, subtract if it fits.
    trial    = {rem_q, quo_q[WIDTH]};
    qbit     = (trial >= {1'b0, dvs_q});
    rem_step = qbit ? (WIDTH+1)'(trial - {1'b0, dvs_q}) : (WIDTH+1)'(trial);
    quo_step = {quo_q[WIDTH-1:0], qbit};
    q_ext    = (2*WIDTH)'(quo_step);
`ifdef SEQ_DIV_REMAINDER_EN
    r_mag    = WIDTH'(rem_step);
`endif

    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    neg_d      = neg_q;
    quotient_d = quotient_q;
    error_d    = error_q;
`ifdef SEQ_DIV_REMAINDER_EN
    dnd_neg_d   = dnd_neg_q;
    remainder_d = remainder_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          neg_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          dvs_d = dvs_mag;
          // The magnitude MSB is always 0 (max 2^(WIDTH-1)), so it seeds the
          // partial remainder directly and only WIDTH real steps remain.
          rem_d = (WIDTH+1)'(dnd_mag[WIDTH]);
          quo_d = {dnd_mag[WIDTH-1:0], 1'b0};
          cnt_d = '0;
`ifdef SEQ_DIV_REMAINDER_EN
          dnd_neg_d = dividend[WIDTH-1];
`endif
          if (divisor == '0) begin
            state_d    = FIN;
            quotient_d = '0;
            error_d    = 1'b1;
`ifdef SEQ_DIV_REMAINDER_EN
            remainder_d = '0;
`endif
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) begin
          // Results are registered on the edge entering FIN so they are valid
          // for the whole done cycle.
          state_d    = FIN;
          quotient_d = neg_q ? -q_ext : q_ext;
          error_d    = 1'b0;
`ifdef SEQ_DIV_REMAINDER_EN
          remainder_d = dnd_neg_q ? -r_mag : r_mag;
`endif
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      neg_q      <= 1'b0;
      quotient_q <= '0;
      error_q    <= 1'b0;
`ifdef SEQ_DIV_REMAINDER_EN
      dnd_neg_q   <= 1'b0;
      remainder_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      neg_q      <= neg_d;
      quotient_q <= quotient_d;
      error_q    <= error_d;
`ifdef SEQ_DIV_REMAINDER_EN
      dnd_neg_q   <= dnd_neg_d;
      remainder_q <= remainder_d;
`endif
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == FIN);
  assign quotient = quotient_q;
  assign error    = error_q;
`ifdef SEQ_DIV_REMAINDER_EN
  assign remainder = remainder_q;
`endif

endmodule

// File: tb/tb_seq_divide.sv
// tb_seq_divide -- scoreboard bench for seq_divide (WIDTH=16).
// The driver pushes the expected result and the expected done edge for every
// issued division; a monitor pops and compares whenever done is seen.

module tb_seq_divide;

  localparam int W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [W-1:0]     dividend = '0;
  logic [W-1:0]     divisor = '0;
  logic             busy;
  logic             done;
  logic [2*W-1:0]   quotient;
  logic             error;
`ifdef SEQ_DIV_REMAINDER_EN
  logic [W-1:0]     remainder;
`endif

  int tests  = 0;
  int fails  = 0;
  int edge_n = 0;
  int txn_id = 0;

  typedef struct {
    logic [2*W-1:0] q;
    logic [W-1:0]   r;
    logic           e;
    int             edge_no;
    int             id;
  } exp_t;

  exp_t exp_q[$];

  seq_divide #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .quotient (quotient),
`ifdef SEQ_DIV_REMAINDER_EN
    .remainder(remainder),
`endif
    .error    (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: compare every done pulse against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        check("done_spurious", 64'(done), 64'(0));
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        check("quotient", 64'(quotient), 64'(x.q));
        check("error", 64'(error), 64'(x.e));
        check("done_edge", 64'(edge_n), 64'(x.edge_no));
`ifdef SEQ_DIV_REMAINDER_EN
        check("remainder", 64'(remainder), 64'(x.r));
`endif
        $display("[TB] txn %0d: quotient=0x%08h error=%0b done_edge=%0d", x.id, quotient, error, edge_n);
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the start edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2*W-1:0] q, input logic [W-1:0] r, input logic e);
    int   guard;
    exp_t x;
    guard = 0;
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (busy) check("idle_timeout", 64'(busy), 64'(0));
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    x.q       = q;
    x.r       = r;
    x.e       = e;
    x.edge_no = edge_n + 1 + ((b == '0) ? 0 : W);
    x.id      = txn_id;
    txn_id++;
    exp_q.push_back(x);
    @(negedge clk);
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    check("busy_after_start", 64'(busy), 64'(1));
  endtask

  initial begin
    int guard;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_quotient", 64'(quotient), 64'(0));
    check("rst_error", 64'(error), 64'(0));
`ifdef SEQ_DIV_REMAINDER_EN
    check("rst_remainder", 64'(remainder), 64'(0));
`endif

    // Release reset and start on the very first edge after it.
    rst_n = 1'b1;
    issue(16'd32000, 16'd16000, 32'h0000_0002, 16'h0000, 1'b0);
    issue(16'd11,    16'd0,     32'h0000_0000, 16'h0000, 1'b1);
    issue(16'd11,    16'd15,    32'h0000_0000, 16'h000B, 1'b0);
    issue(16'hFFF9,  16'd2,     32'hFFFF_FFFD, 16'hFFFF, 1'b0);  // -7 / 2
    issue(16'd7,     16'hFFFE,  32'hFFFF_FFFD, 16'h0001, 1'b0);  // 7 / -2
    issue(16'h8000,  16'hFFFF,  32'h0000_8000, 16'h0000, 1'b0);  // -32768 / -1
    issue(16'h8000,  16'd1,     32'hFFFF_8000, 16'h0000, 1'b0);  // -32768 / 1
    issue(16'd100,   16'd7,     32'h0000_000E, 16'h0002, 1'b0);
    issue(16'hFF9C,  16'hFFF9,  32'h0000_000E, 16'hFFFE, 1'b0);  // -100 / -7
    issue(16'h7FFF,  16'h8000,  32'h0000_0000, 16'h7FFF, 1'b0);  // 32767 / -32768

    // A start pulse at cycle 5 of a busy division must be ignored.
    issue(16'd1234,  16'd10,    32'h0000_007B, 16'h0004, 1'b0);
    repeat (4) @(negedge clk);
    dividend = 16'd5555;
    divisor  = 16'd0;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;

    // Reset at cycle 8 of a division discards it without a done pulse.
    issue(16'd1000,  16'd3,     32'h0000_014D, 16'h0001, 1'b0);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_done", 64'(done), 64'(0));
    check("midrst_quotient", 64'(quotient), 64'(0));
    check("midrst_error", 64'(error), 64'(0));
`ifdef SEQ_DIV_REMAINDER_EN
    check("midrst_remainder", 64'(remainder), 64'(0));
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(16'd9,     16'hFFFD,  32'hFFFF_FFFD, 16'h0000, 1'b0);  // 9 / -3

    // Drain the scoreboard with a bounded wait.
    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("drain_pending", 64'(exp_q.size()), 64'(0));
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
